// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch sequencer
// Contents:
//   fetch_state_e  FSM states of the fetch sequencer
//   redir_src_e    redirect source; numeric order is priority (EXC highest)
//   PC_STEP        sequential PC increment applied by the PC register
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    // Ordered so that a plain magnitude compare gives redirect priority.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        JMP  = 2'd1,
        BR   = 2'd2,
        EXC  = 2'd3
    } redir_src_e;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/redirect_merge.sv
// rtl/redirect_merge.sv - redirect priority select and pending-redirect register
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   excValid/excTarget             exception redirect request
//   brValid/brTarget               taken-branch redirect request
//   jmpValid/jmpTarget             jump redirect request
//   apply                          selected redirect is applied this cycle; clear pending
//   selValid/selTarget             best of pending and incoming redirect, this cycle
//   newValid                       some redirect request arrives this cycle
module redirect_merge
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              excValid,
    input  logic [ADDR_W-1:0] excTarget,
    input  logic              brValid,
    input  logic [ADDR_W-1:0] brTarget,
    input  logic              jmpValid,
    input  logic [ADDR_W-1:0] jmpTarget,
    input  logic              apply,
    output logic              selValid,
    output logic [ADDR_W-1:0] selTarget,
    output logic              newValid
);

    redir_src_e        pendSrc;
    logic [ADDR_W-1:0] pendTarget;
    redir_src_e        inSrc;
    logic [ADDR_W-1:0] inTarget;
    redir_src_e        selSrc;

    always_comb begin
        inSrc    = NONE;
        inTarget = '0;
        if (excValid) begin
            inSrc    = EXC;
            inTarget = excTarget;
        end else if (brValid) begin
            inSrc    = BR;
            inTarget = brTarget;
        end else if (jmpValid) begin
            inSrc    = JMP;
            inTarget = jmpTarget;
        end
    end

    // A new request replaces the pending one unless the pending one outranks it;
    // at equal rank the younger request wins.
    always_comb begin
        selSrc    = pendSrc;
        selTarget = pendTarget;
        if (inSrc != NONE && inSrc >= pendSrc) begin
            selSrc    = inSrc;
            selTarget = inTarget;
        end
    end

    assign selValid = (selSrc != NONE);
    assign newValid = (inSrc != NONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pendSrc    <= NONE;
            pendTarget <= '0;
        end else if (apply) begin
            pendSrc    <= NONE;
            pendTarget <= '0;
        end else begin
            pendSrc    <= selSrc;
            pendTarget <= selTarget;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC control, single-outstanding imem fetch, redirect squash, 1-entry buffer
// Optional feature macro: FETCH_SEQ_PERF_EN (adds PERF_W-wide performance counters).
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   i_pc                            current PC from the PC register
//   i_stall                         hazard stall, blocks new fetches only
//   i_exc_*/i_br_*/i_jmp_*          redirect requests (priority exc > br > jmp)
//   o_pc_pause/o_pc_we/o_pc_next    PC register control
//   o_imem_req/o_imem_addr          fetch request, held until i_imem_ack
//   i_imem_ack/i_imem_rdata         fetch completion and data
//   o_inst_valid/o_inst/o_inst_pc   output buffer to decode
//   i_inst_ready                    decode consumes the buffer
//   o_perf_*_cnt                    fetch/redirect/hold counters (FETCH_SEQ_PERF_EN only)
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef FETCH_SEQ_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_stall,
    input  logic              i_exc_valid,
    input  logic [ADDR_W-1:0] i_exc_target,
    input  logic              i_br_valid,
    input  logic [ADDR_W-1:0] i_br_target,
    input  logic              i_jmp_valid,
    input  logic [ADDR_W-1:0] i_jmp_target,
    output logic              o_pc_pause,
    output logic              o_pc_we,
    output logic [ADDR_W-1:0] o_pc_next,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [DATA_W-1:0] i_imem_rdata,
    output logic              o_inst_valid,
    output logic [DATA_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_inst_pc,
`ifdef FETCH_SEQ_PERF_EN
    output logic [PERF_W-1:0] o_perf_fetch_cnt,
    output logic [PERF_W-1:0] o_perf_redirect_cnt,
    output logic [PERF_W-1:0] o_perf_stall_cnt,
`endif
    input  logic              i_inst_ready
);

    fetch_state_e      state;
    fetch_state_e      nextState;
    logic              selValid;
    logic [ADDR_W-1:0] selTarget;
    logic              newValid;
    logic              apply;
    logic              commit;
    logic              ackNow;
    logic              canStart;

    redirect_merge #(.ADDR_W(ADDR_W)) u_redirect_merge (
        .clk       (clk),
        .rstn      (rstn),
        .excValid  (i_exc_valid),
        .excTarget (i_exc_target),
        .brValid   (i_br_valid),
        .brTarget  (i_br_target),
        .jmpValid  (i_jmp_valid),
        .jmpTarget (i_jmp_target),
        .apply     (apply),
        .selValid  (selValid),
        .selTarget (selTarget),
        .newValid  (newValid)
    );

    // FETCH means a request is outstanding. The PC is paused for the whole
    // request, so driving the address straight from i_pc keeps it stable.
    assign o_imem_req  = (state == FETCH);
    assign o_imem_addr = (state == FETCH) ? i_pc : '0;
    assign ackNow      = (state == FETCH) && i_imem_ack;
    assign canStart    = !i_stall && (!o_inst_valid || i_inst_ready);

    always_comb begin
        nextState  = state;
        o_pc_pause = 1'b1;
        o_pc_we    = 1'b0;
        o_pc_next  = '0;
        apply      = 1'b0;
        commit     = 1'b0;
        case (state)
            FETCH: begin
                if (ackNow) begin
                    o_pc_pause = 1'b0;
                    if (selValid) begin
                        // Wrong-path data: drop it and jump the PC instead of +4.
                        o_pc_we   = 1'b1;
                        o_pc_next = selTarget;
                        apply     = 1'b1;
                        nextState = i_stall ? HOLD : FETCH;
                    end else begin
                        // The buffer is full next cycle, so the next fetch
                        // waits in HOLD until decode frees it.
                        commit    = 1'b1;
                        nextState = HOLD;
                    end
                end
            end
            default: begin
                if (selValid) begin
                    o_pc_pause = 1'b0;
                    o_pc_we    = 1'b1;
                    o_pc_next  = selTarget;
                    apply      = 1'b1;
                    nextState  = i_stall ? HOLD : FETCH;
                end else begin
                    nextState = canStart ? FETCH : HOLD;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Any arriving redirect makes the buffered instruction wrong-path. A commit
    // never coincides with one, because a live redirect forces a squash.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_inst_valid <= 1'b0;
            o_inst       <= '0;
            o_inst_pc    <= '0;
        end else if (newValid) begin
            o_inst_valid <= 1'b0;
        end else if (commit) begin
            o_inst_valid <= 1'b1;
            o_inst       <= i_imem_rdata;
            o_inst_pc    <= o_imem_addr;
        end else if (o_inst_valid && i_inst_ready) begin
            o_inst_valid <= 1'b0;
        end
    end

`ifdef FETCH_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_perf_fetch_cnt    <= '0;
            o_perf_redirect_cnt <= '0;
            o_perf_stall_cnt    <= '0;
        end else begin
            if (commit) begin
                o_perf_fetch_cnt <= o_perf_fetch_cnt + 1'b1;
            end
            if (apply) begin
                o_perf_redirect_cnt <= o_perf_redirect_cnt + 1'b1;
            end
            if (state == HOLD) begin
                o_perf_stall_cnt <= o_perf_stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic        clk;
    logic        rstn;
    logic [31:0] pc;
    logic        stall;
    logic        excValid, brValid, jmpValid;
    logic [31:0] excTarget, brTarget, jmpTarget;
    logic        pcPause, pcWe;
    logic [31:0] pcNext;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic        instValid;
    logic [31:0] inst;
    logic [31:0] instPc;
    logic        instReady;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] perfFetch, perfRedirect, perfStall;
`endif

    int total = 0;
    int bad   = 0;

    fetch_sequencer dut (
        .clk                 (clk),
        .rstn                (rstn),
        .i_pc                (pc),
        .i_stall             (stall),
        .i_exc_valid         (excValid),
        .i_exc_target        (excTarget),
        .i_br_valid          (brValid),
        .i_br_target         (brTarget),
        .i_jmp_valid         (jmpValid),
        .i_jmp_target        (jmpTarget),
        .o_pc_pause          (pcPause),
        .o_pc_we             (pcWe),
        .o_pc_next           (pcNext),
        .o_imem_req          (imemReq),
        .o_imem_addr         (imemAddr),
        .i_imem_ack          (imemAck),
        .i_imem_rdata        (imemRdata),
        .o_inst_valid        (instValid),
        .o_inst              (inst),
        .o_inst_pc           (instPc),
`ifdef FETCH_SEQ_PERF_EN
        .o_perf_fetch_cnt    (perfFetch),
        .o_perf_redirect_cnt (perfRedirect),
        .o_perf_stall_cnt    (perfStall),
`endif
        .i_inst_ready        (instReady)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PC register environment model: resets to 4, holds, loads or steps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc <= 32'h4;
        end else if (!pcPause) begin
            pc <= pcWe ? pcNext : pc + PC_STEP;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkReset(input string tag);
        chk({tag, "_pause"}, pcPause, 1'b1);
        chk({tag, "_we"}, pcWe, 1'b0);
        chk({tag, "_next"}, pcNext, 32'h0);
        chk({tag, "_req"}, imemReq, 1'b0);
        chk({tag, "_addr"}, imemAddr, 32'h0);
        chk({tag, "_valid"}, instValid, 1'b0);
        chk({tag, "_inst"}, inst, 32'h0);
        chk({tag, "_instpc"}, instPc, 32'h0);
`ifdef FETCH_SEQ_PERF_EN
        chk({tag, "_perf_fetch"}, perfFetch, 32'h0);
        chk({tag, "_perf_redir"}, perfRedirect, 32'h0);
        chk({tag, "_perf_stall"}, perfStall, 32'h0);
`endif
    endtask

    initial begin
        rstn = 1'b0; stall = 1'b0; instReady = 1'b1;
        excValid = 1'b0; brValid = 1'b0; jmpValid = 1'b0;
        excTarget = '0; brTarget = '0; jmpTarget = '0;
        imemAck = 1'b0; imemRdata = '0;
        cyc(); cyc();
        chkReset("rst0");
        rstn = 1'b1;
        #1;
        chk("idle_req", imemReq, 1'b0);

        // Sequential fetches 0x4 and 0x8, ack one cycle after req.
        cyc();
        chk("f4_req", imemReq, 1'b1);
        chk("f4_addr", imemAddr, 32'h4);
        chk("f4_pause", pcPause, 1'b1);
        imemAck = 1'b1; imemRdata = 32'h1111_0004; #1;
        chk("f4_ack_pause", pcPause, 1'b0);
        chk("f4_ack_we", pcWe, 1'b0);
        cyc(); imemAck = 1'b0; #1;
        chk("f4_valid", instValid, 1'b1);
        chk("f4_inst", inst, 32'h1111_0004);
        chk("f4_instpc", instPc, 32'h4);
        chk("f4_hold_req", imemReq, 1'b0);
        cyc();
        chk("f8_req", imemReq, 1'b1);
        chk("f8_addr", imemAddr, 32'h8);
        chk("f8_drained", instValid, 1'b0);
        cyc(); imemAck = 1'b1; imemRdata = 32'h2222_0008; #1;
        cyc(); imemAck = 1'b0; instReady = 1'b0; #1;
        chk("f8_valid", instValid, 1'b1);
        chk("f8_instpc", instPc, 32'h8);

        // Decode back-pressure: buffer full, no new request.
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_req", imemReq, 1'b0);
            chk("bp_inst", inst, 32'h2222_0008);
            chk("bp_pause", pcPause, 1'b1);
            chk("bp_valid", instValid, 1'b1);
        end
        cyc(); instReady = 1'b1; #1;
        chk("bp_release_req", imemReq, 1'b0);
        cyc();
        chk("fc_req", imemReq, 1'b1);
        chk("fc_addr", imemAddr, 32'hC);

        // Stall in the ack cycle: commit still happens, no new request while stalled.
        cyc(); imemAck = 1'b1; imemRdata = 32'h3333_000C; stall = 1'b1; #1;
        chk("st_ack_pause", pcPause, 1'b0);
        chk("st_ack_we", pcWe, 1'b0);
        cyc(); imemAck = 1'b0; #1;
        chk("st_valid", instValid, 1'b1);
        chk("st_instpc", instPc, 32'hC);
        chk("st_req0", imemReq, 1'b0);
        cyc();
        chk("st_req1", imemReq, 1'b0);
        cyc();
        chk("st_req2", imemReq, 1'b0);
        cyc(); stall = 1'b0; #1;
        chk("st_req3", imemReq, 1'b0);
        cyc();
        chk("f10_req", imemReq, 1'b1);
        chk("f10_addr", imemAddr, 32'h10);

        // Branch while the fetch is outstanding: ack data squashed.
        brValid = 1'b1; brTarget = 32'h100; #1;
        chk("br_pause", pcPause, 1'b1);
        cyc(); brValid = 1'b0; imemAck = 1'b1; imemRdata = 32'h4444_0010; #1;
        chk("br_ack_pause", pcPause, 1'b0);
        chk("br_ack_we", pcWe, 1'b1);
        chk("br_ack_next", pcNext, 32'h100);
        cyc(); imemAck = 1'b0; #1;
        chk("br_dropped", instValid, 1'b0);
        chk("br_req", imemReq, 1'b1);
        chk("br_addr", imemAddr, 32'h100);

        // Exception, branch and jump in the same cycle: exception wins.
        excValid = 1'b1; excTarget = 32'h80;
        brValid = 1'b1; brTarget = 32'h100;
        jmpValid = 1'b1; jmpTarget = 32'h200; #1;
        cyc(); excValid = 1'b0; brValid = 1'b0; jmpValid = 1'b0; imemAck = 1'b1; #1;
        chk("pri_we", pcWe, 1'b1);
        chk("pri_next", pcNext, 32'h80);
        cyc(); imemAck = 1'b0; #1;
        chk("pri_addr", imemAddr, 32'h80);
        chk("pri_valid", instValid, 1'b0);

        // Pending jump overwritten by a later branch.
        jmpValid = 1'b1; jmpTarget = 32'h200; #1;
        cyc(); jmpValid = 1'b0; brValid = 1'b1; brTarget = 32'h300; #1;
        chk("ow_pause", pcPause, 1'b1);
        cyc(); brValid = 1'b0; imemAck = 1'b1; #1;
        chk("ow_next", pcNext, 32'h300);
        chk("ow_we", pcWe, 1'b1);
        cyc(); imemAck = 1'b0; #1;
        chk("ow_addr", imemAddr, 32'h300);

        // Redirect while holding a full buffer: applied at once, buffer flushed.
        imemAck = 1'b1; imemRdata = 32'h5555_0300; instReady = 1'b0; #1;
        cyc(); imemAck = 1'b0; #1;
        chk("hr_valid", instValid, 1'b1);
        chk("hr_instpc", instPc, 32'h300);
        cyc(); jmpValid = 1'b1; jmpTarget = 32'h200; #1;
        chk("hr_pause", pcPause, 1'b0);
        chk("hr_we", pcWe, 1'b1);
        chk("hr_next", pcNext, 32'h200);
        cyc(); jmpValid = 1'b0; instReady = 1'b1; #1;
        chk("hr_flushed", instValid, 1'b0);
        chk("hr_req", imemReq, 1'b1);
        chk("hr_addr", imemAddr, 32'h200);
`ifdef FETCH_SEQ_PERF_EN
        chk("perf_fetch", perfFetch, 32'd4);
        chk("perf_redir", perfRedirect, 32'd4);
`endif

        // Reset while a request is outstanding; a late ack must be ignored.
        rstn = 1'b0; imemAck = 1'b1; #1;
        chkReset("rst_mid");
        cyc(); cyc();
        rstn = 1'b1; #1;
        chk("late_ack_pause", pcPause, 1'b1);
        chk("late_ack_we", pcWe, 1'b0);
        chk("late_ack_valid", instValid, 1'b0);
        imemAck = 1'b0;
        cyc();
        chk("rr_req", imemReq, 1'b1);
        chk("rr_addr", imemAddr, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        bad++;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
